rv32i_exec_unit: RTL and testbench

Combined decode / execute / data-memory slice of the multi-cycle RV32I core (IF→DE→EX→MA→WB, one instruction per 5 cycles).
- Decodes a 32-bit instruction into fields, immediate and class flags.
- Computes the ALU/branch/address result.
- Holds the byte-addressable data memory with RV32I load/store sizing.
- PC, register file and FSM stay in the enclosing core, which drives mem_we only in the MA state.

---
 rtl/rv32i_pkg.sv | 56 +++++
 rtl/rv32i_decoder.sv | 31 +++
 rtl/rv32i_exec_unit.sv | 123 ++++++++++++
 tb/tb_rv32i_exec_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: opcodes, funct3 codes and decode bundle shared by the RV32I exec slice
package rv32i_pkg;
  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        is_arith;
    logic        is_arith_imm;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_lui;
    logic        is_auipc;
  } decode_t;
endpackage

// File: rtl/rv32i_decoder.sv
// rv32i_decoder: splits an instruction into fields, class flags and sign-extended immediate
import rv32i_pkg::*;

module rv32i_decoder (
  input  logic [31:0] inst,
  output decode_t     dec
);
  always_comb begin
    dec              = '0;
    dec.rs1          = inst[19:15];
    dec.rs2          = inst[24:20];
    dec.rd           = inst[11:7];
    dec.funct3       = inst[14:12];
    dec.funct7       = inst[31:25];
    dec.is_arith     = inst[6:0] == OP_ARITH;
    dec.is_arith_imm = inst[6:0] == OP_ARITH_IMM;
    dec.is_load      = inst[6:0] == OP_LOAD;
    dec.is_store     = inst[6:0] == OP_STORE;
    dec.is_branch    = inst[6:0] == OP_BRANCH;
    dec.is_jal       = inst[6:0] == OP_JAL;
    dec.is_jalr      = inst[6:0] == OP_JALR;
    dec.is_lui       = inst[6:0] == OP_LUI;
    dec.is_auipc     = inst[6:0] == OP_AUIPC;
    dec.imm = (dec.is_arith_imm | dec.is_load | dec.is_jalr) ? {{20{inst[31]}}, inst[31:20]} :
              dec.is_store  ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
              dec.is_branch ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
              (dec.is_lui | dec.is_auipc) ? {inst[31:12], 12'b0} :
              dec.is_jal    ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
              32'b0;
  end
endmodule

// File: rtl/rv32i_exec_unit.sv
// rv32i_exec_unit: decode, ALU/branch/address and byte-addressable data memory of the multi-cycle core
import rv32i_pkg::*;

module rv32i_exec_unit #(
  parameter int MEM_SIZE  = 4096,
  parameter int ADDR_SIZE = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        mem_we,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic        is_arith,
  output logic        is_arith_imm,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        is_jal,
  output logic        is_jalr,
  output logic        is_lui,
  output logic        is_auipc,
  output logic [31:0] alu_out,
  output logic [31:0] load_data
);
  localparam int WORDS = MEM_SIZE / 4;

  decode_t dec;

  rv32i_decoder u_dec (.inst(inst), .dec(dec));

  assign rs1          = dec.rs1;
  assign rs2          = dec.rs2;
  assign rd           = dec.rd;
  assign funct3       = dec.funct3;
  assign funct7       = dec.funct7;
  assign imm          = dec.imm;
  assign is_arith     = dec.is_arith;
  assign is_arith_imm = dec.is_arith_imm;
  assign is_load      = dec.is_load;
  assign is_store     = dec.is_store;
  assign is_branch    = dec.is_branch;
  assign is_jal       = dec.is_jal;
  assign is_jalr      = dec.is_jalr;
  assign is_lui       = dec.is_lui;
  assign is_auipc     = dec.is_auipc;

  logic [31:0] op_b, alu_r;
  logic [4:0]  shamt;
  logic        taken;

  always_comb begin
    op_b  = dec.is_arith ? rs2_data : dec.imm;
    shamt = op_b[4:0];
    case (dec.funct3)
      F3_ADD:  alu_r = (dec.is_arith && dec.funct7[5]) ? rs1_data - op_b : rs1_data + op_b;
      F3_SLL:  alu_r = rs1_data << shamt;
      F3_SLT:  alu_r = {31'b0, $signed(rs1_data) < $signed(op_b)};
      F3_SLTU: alu_r = {31'b0, rs1_data < op_b};
      F3_XOR:  alu_r = rs1_data ^ op_b;
      F3_SR:   alu_r = dec.funct7[5] ? $unsigned($signed(rs1_data) >>> shamt) : rs1_data >> shamt;
      F3_OR:   alu_r = rs1_data | op_b;
      default: alu_r = rs1_data & op_b;
    endcase
    case (dec.funct3)
      F3_BEQ:  taken = rs1_data == rs2_data;
      F3_BNE:  taken = rs1_data != rs2_data;
      F3_BLT:  taken = $signed(rs1_data) < $signed(rs2_data);
      F3_BGE:  taken = $signed(rs1_data) >= $signed(rs2_data);
      F3_BLTU: taken = rs1_data < rs2_data;
      F3_BGEU: taken = rs1_data >= rs2_data;
      default: taken = 1'b0;
    endcase
    alu_out = (dec.is_arith | dec.is_arith_imm) ? alu_r :
              dec.is_branch ? {31'b0, taken} :
              (dec.is_load | dec.is_store) ? rs1_data + dec.imm :
              32'b0;
  end

  // Bits above ADDR_SIZE are dropped, so addresses alias modulo the memory span
  logic [31:0]          mem_q [WORDS];
  logic [ADDR_SIZE-2:0] idx;
  logic [1:0]           lane;
  logic [31:0]          rd_word, wr_d;
  logic [7:0]           byte_v;
  logic [15:0]          half_v;
  logic                 wr_en;

  assign idx     = alu_out[ADDR_SIZE:2];
  assign lane    = alu_out[1:0];
  assign rd_word = mem_q[idx];
  assign byte_v  = rd_word[{lane, 3'b0} +: 8];
  assign half_v  = rd_word[{lane[1], 4'b0} +: 16];
  assign wr_en   = mem_we & dec.is_store & (dec.funct3 inside {F3_SB, F3_SH, F3_SW});

  always_comb begin
    wr_d = rd_word;
    case (dec.funct3)
      F3_SB:   wr_d[{lane, 3'b0} +: 8] = rs2_data[7:0];
      F3_SH:   wr_d[{lane[1], 4'b0} +: 16] = rs2_data[15:0];
      F3_SW:   wr_d = rs2_data;
      default: wr_d = rd_word;
    endcase
    load_data = !dec.is_load ? 32'b0 :
                dec.funct3 == F3_LB  ? {{24{byte_v[7]}}, byte_v} :
                dec.funct3 == F3_LH  ? {{16{half_v[15]}}, half_v} :
                dec.funct3 == F3_LW  ? rd_word :
                dec.funct3 == F3_LBU ? {24'b0, byte_v} :
                dec.funct3 == F3_LHU ? {16'b0, half_v} :
                32'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    else if (wr_en) mem_q[idx] <= wr_d;
  end
endmodule

// File: tb/tb_rv32i_exec_unit.sv
// tb_rv32i_exec_unit: directed and randomized checks against a byte-level reference model
module tb_rv32i_exec_unit;
  logic        clk = 0, rst = 0, mem_we = 0;
  logic [31:0] inst = 0, rs1_data = 0, rs2_data = 0;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm, alu_out, load_data;
  logic        is_arith, is_arith_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;

  rv32i_exec_unit dut (
    .clk(clk), .rst(rst), .inst(inst), .rs1_data(rs1_data), .rs2_data(rs2_data), .mem_we(mem_we),
    .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3), .funct7(funct7), .imm(imm),
    .is_arith(is_arith), .is_arith_imm(is_arith_imm), .is_load(is_load), .is_store(is_store),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .is_lui(is_lui), .is_auipc(is_auipc),
    .alu_out(alu_out), .load_data(load_data)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [7:0] mem_m [4096];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_inst(logic [6:0] f7, logic [4:0] s2, logic [4:0] s1, logic [2:0] f3, logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_inst(logic [11:0] im, logic [4:0] s1, logic [2:0] f3, logic [4:0] d, logic [6:0] op);
    return {im, s1, f3, d, op};
  endfunction
  function automatic logic [31:0] s_inst(logic [11:0] im, logic [4:0] s2, logic [4:0] s1, logic [2:0] f3);
    return {im[11:5], s2, s1, f3, im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] b_inst(logic [12:0] im, logic [4:0] s2, logic [4:0] s1, logic [2:0] f3);
    return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] sext12(logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic logic [31:0] ref_imm(logic [31:0] i);
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: return sext12(i[31:20]);
      7'b0100011: return sext12({i[31:25], i[11:7]});
      7'b1100011: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'b0110111, 7'b0010111: return {i[31:12], 12'b0};
      7'b1101111: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(bit is_r, logic [2:0] f3, logic [6:0] f7, logic [31:0] a, logic [31:0] b);
    int sh = b[4:0];
    case (f3)
      0: return (is_r && f7[5]) ? a - b : a + b;
      1: return a << sh;
      2: return ($signed(a) < $signed(b)) ? 1 : 0;
      3: return (a < b) ? 1 : 0;
      4: return a ^ b;
      5: return f7[5] ? $unsigned($signed(a) >>> sh) : a >> sh;
      6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] ref_branch(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    case (f3)
      0: return {31'b0, a == b};
      1: return {31'b0, a != b};
      4: return {31'b0, $signed(a) < $signed(b)};
      5: return {31'b0, $signed(a) >= $signed(b)};
      6: return {31'b0, a < b};
      7: return {31'b0, a >= b};
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] addr);
    int a = addr[11:0];
    int w = a & ~3;
    int h = w + (a & 2);
    logic [7:0] b = mem_m[a];
    logic [15:0] hv = {mem_m[h + 1], mem_m[h]};
    case (f3)
      0: return {{24{b[7]}}, b};
      1: return {{16{hv[15]}}, hv};
      2: return {mem_m[w + 3], mem_m[w + 2], mem_m[w + 1], mem_m[w]};
      4: return {24'b0, b};
      5: return {16'b0, hv};
      default: return 0;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4096; i++) mem_m[i] = 0;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data, input logic we);
    int a = addr[11:0];
    @(negedge clk);
    inst = s_inst(12'd0, 5'd2, 5'd1, f3);
    rs1_data = addr;
    rs2_data = data;
    mem_we = we;
    @(posedge clk);
    #1 mem_we = 0;
    if (we) begin
      if (f3 == 0) mem_m[a] = data[7:0];
      if (f3 == 1) {mem_m[(a & ~3) + (a & 2) + 1], mem_m[(a & ~3) + (a & 2)]} = data[15:0];
      if (f3 == 2) {mem_m[(a & ~3) + 3], mem_m[(a & ~3) + 2], mem_m[(a & ~3) + 1], mem_m[a & ~3]} = data;
    end
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [11:0] offs);
    inst = i_inst(offs, 5'd1, f3, 5'd5, 7'b0000011);
    rs1_data = addr - sext12(offs);
    #1;
  endtask

  logic [6:0]  ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011};

  initial begin
    logic [31:0] r, a, b, exp;
    logic [11:0] im;
    logic [2:0]  f3;
    logic [6:0]  f7;
    bit          is_r;
    int          k;
    model_clear();
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    do_load(3'd2, 32'h0, 12'd0);
    chk("reset_lw0", load_data, 32'h0);

    inst = 32'h00500513; rs1_data = 0; #1;
    chk("addi_rd", {27'b0, rd}, 32'd10);
    chk("addi_rs1", {27'b0, rs1}, 32'd0);
    chk("addi_flag", {31'b0, is_arith_imm}, 32'd1);
    chk("addi_imm", imm, 32'd5);
    chk("addi_alu", alu_out, 32'd5);

    inst = 32'hFE000EE3; rs1_data = 7; rs2_data = 7; #1;
    chk("beq_inst_enc", b_inst(-13'sd4, 5'd0, 5'd0, 3'd0), inst);
    chk("beq_imm", imm, 32'hFFFFFFFC);
    chk("beq_taken", alu_out, 32'd1);
    rs2_data = 8; #1;
    chk("beq_not_taken", alu_out, 32'd0);

    inst = r_inst(7'h20, 5'd2, 5'd1, 3'b101, 5'd3); rs1_data = 32'h80000000; rs2_data = 4; #1;
    chk("sra", alu_out, 32'hF8000000);
    inst = r_inst(7'h00, 5'd2, 5'd1, 3'b101, 5'd3); #1;
    chk("srl", alu_out, 32'h08000000);
    inst = r_inst(7'h00, 5'd2, 5'd1, 3'b010, 5'd3); rs1_data = 32'hFFFFFFFF; rs2_data = 1; #1;
    chk("slt", alu_out, 32'd1);
    inst = r_inst(7'h00, 5'd2, 5'd1, 3'b011, 5'd3); #1;
    chk("sltu", alu_out, 32'd0);

    do_store(3'd2, 32'h100, 32'h12345678, 1);
    do_store(3'd0, 32'h101, 32'h000000AB, 1);
    do_load(3'd2, 32'h100, 12'd0);  chk("lw_100", load_data, 32'h1234AB78);
    do_load(3'd0, 32'h101, 12'd0);  chk("lb_101", load_data, 32'hFFFFFFAB);
    do_load(3'd4, 32'h101, 12'd0);  chk("lbu_101", load_data, 32'h000000AB);
    do_load(3'd1, 32'h102, 12'd0);  chk("lh_102", load_data, 32'h00001234);
    do_store(3'd2, 32'h100, 32'h0, 0);
    do_load(3'd2, 32'h100, 12'd0);  chk("we_gated", load_data, 32'h1234AB78);
    do_store(3'd2, 32'h1000, 32'hDEADBEEF, 1);
    do_load(3'd2, 32'h0, 12'd0);    chk("wrap_lw0", load_data, 32'hDEADBEEF);

    do_store(3'd2, 32'h200, 32'hCAFEF00D, 1);
    @(negedge clk);
    inst = s_inst(12'd0, 5'd2, 5'd1, 3'd2); rs1_data = 32'h300; rs2_data = 32'h55555555;
    mem_we = 1; rst = 1;
    @(posedge clk);
    #1 begin mem_we = 0; rst = 0; end
    model_clear();
    do_load(3'd2, 32'h100, 12'd0);  chk("rst_lw100", load_data, 32'h0);
    do_load(3'd2, 32'h0, 12'd0);    chk("rst_lw0", load_data, 32'h0);
    do_load(3'd2, 32'h200, 12'd0);  chk("rst_lw200", load_data, 32'h0);
    do_load(3'd2, 32'h300, 12'd0);  chk("rst_store_dropped", load_data, 32'h0);

    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(0, 10);
      r = $urandom;
      inst = {r[31:7], ops[k]};
      rs1_data = $urandom; rs2_data = $urandom;
      #1;
      exp = (k < 9) ? (32'h100 >> k) : 32'h0;
      chk("rnd_flags", {23'b0, is_arith, is_arith_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc}, exp);
      chk("rnd_imm", imm, ref_imm(inst));
      chk("rnd_fields", {rs1, rs2, rd, funct3, funct7}, {inst[19:15], inst[24:20], inst[11:7], inst[14:12], inst[31:25]});
      if (k >= 5) chk("rnd_alu_zero", alu_out, 32'h0);
      if (k != 2) chk("rnd_ld_zero", load_data, 32'h0);
    end

    for (int n = 0; n < 40; n++) begin
      is_r = $urandom_range(0, 1) == 1;
      f3 = 3'($urandom_range(0, 7));
      f7 = $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00;
      r = $urandom;
      im = r[11:0];
      a = $urandom; b = $urandom;
      inst = is_r ? r_inst(f7, 5'd2, 5'd1, f3, 5'd3) : i_inst(im, 5'd1, f3, 5'd3, 7'b0010011);
      rs1_data = a; rs2_data = b;
      #1;
      chk(is_r ? "rnd_alu_r" : "rnd_alu_i", alu_out, ref_alu(is_r, f3, inst[31:25], a, is_r ? b : sext12(im)));
    end

    for (int n = 0; n < 30; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      r = $urandom;
      b = (r[1:0] == 0) ? a : (r[1:0] == 1) ? a ^ 32'h80000000 : $urandom;
      inst = b_inst(13'($urandom), 5'd2, 5'd1, f3);
      rs1_data = a; rs2_data = b;
      #1;
      chk("rnd_branch", alu_out, ref_branch(f3, a, b));
    end

    for (int n = 0; n < 40; n++) begin
      a = $urandom & 32'hFFFFF03F;
      do_store(3'($urandom_range(0, 7)), a, $urandom, $urandom_range(0, 3) != 0);
      r = $urandom;
      b = a ^ {30'b0, r[1:0]};
      f3 = 3'($urandom_range(0, 7));
      do_load(f3, b, r[31:20]);
      chk("rnd_ld_addr", alu_out, b);
      chk("rnd_ld_data", load_data, ref_load(f3, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
